// File: rtl/pipe_hazard_ctrl.sv
// Hazard and forwarding controller for the 5-stage pipeline.
// Produces stall/flush controls for every pipeline register, EX operand forwarding selects,
// a data-memory wait FSM with a timeout watchdog, and saturating stall/flush counters.
module pipe_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [1:0]       resultSrcE,
  input  logic             PCSrcE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             regWriteM,
  input  logic             regWriteW,
  input  logic             memReqM,
  input  logic             mem_ready,
  output logic             stallF,
  output logic             stallD,
  output logic             stallE,
  output logic             stallM,
  output logic             flushD,
  output logic             flushE,
  output logic             flushW,
  output logic [1:0]       forwardAE,
  output logic [1:0]       forwardBE,
  output logic             mem_timeout_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {StRun, StMemWait, StError} state_e;

  // Last wait-counter value tolerated before the watchdog fires.
  localparam logic [15:0] TimeoutLast = 16'(MEM_TIMEOUT - 1);

  state_e           r_state, w_state_nxt;
  logic [15:0]      r_wait_cnt, w_wait_cnt_nxt;
  logic             r_err, w_err_set;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
  logic             w_lw_stall, w_mem_wait;

  assign w_lw_stall = (resultSrcE == 2'b01) && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
  assign w_mem_wait = memReqM && !mem_ready;

  // Next-state, watchdog and combinational pipeline controls; reset forces flush-all.
  always_comb begin
    stallF         = 1'b0;
    stallD         = 1'b0;
    stallE         = 1'b0;
    stallM         = 1'b0;
    flushD         = 1'b0;
    flushE         = 1'b0;
    flushW         = 1'b0;
    forwardAE      = 2'b00;
    forwardBE      = 2'b00;
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    w_err_set      = 1'b0;

    if (regWriteM && (RdM != 5'd0) && (RdM == Rs1E))      forwardAE = 2'b10;
    else if (regWriteW && (RdW != 5'd0) && (RdW == Rs1E)) forwardAE = 2'b01;
    if (regWriteM && (RdM != 5'd0) && (RdM == Rs2E))      forwardBE = 2'b10;
    else if (regWriteW && (RdW != 5'd0) && (RdW == Rs2E)) forwardBE = 2'b01;

    unique case (r_state)
      StRun: begin
        w_wait_cnt_nxt = 16'd0;
        if (w_mem_wait) begin
          // Freeze now; EX is held so branch/load-use re-evaluate after the wait.
          {stallF, stallD, stallE, stallM, flushW} = 5'b11111;
          w_state_nxt = StMemWait;
        end else if (PCSrcE) begin
          flushD = 1'b1;
          flushE = 1'b1;
        end else if (w_lw_stall) begin
          stallF = 1'b1;
          stallD = 1'b1;
          flushE = 1'b1;
        end
      end
      StMemWait: begin
        {stallF, stallD, stallE, stallM, flushW} = 5'b11111;
        if (mem_ready) begin
          w_state_nxt    = StRun;
          w_wait_cnt_nxt = 16'd0;
        end else if (r_wait_cnt == TimeoutLast) begin
          w_state_nxt = StError;
          w_err_set   = 1'b1;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + 16'd1;
        end
      end
      StError: begin
        {stallF, stallD, stallE, stallM, flushW} = 5'b11111;
      end
      default: w_state_nxt = StRun;
    endcase

    if (rst) begin
      {stallF, stallD, stallE, stallM} = 4'b0000;
      {flushD, flushE, flushW}         = 3'b111;
      forwardAE                        = 2'b00;
      forwardBE                        = 2'b00;
    end
  end

  // State, watchdog counter and sticky error register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= StRun;
      r_wait_cnt <= 16'd0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      r_err      <= r_err | w_err_set;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (stallF && (r_stall_cnt != {CNT_W{1'b1}})) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (flushE && (r_flush_cnt != {CNT_W{1'b1}})) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign mem_timeout_err = r_err;
  assign stall_cnt       = r_stall_cnt;
  assign flush_cnt       = r_flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (MEM_TIMEOUT = 4, CNT_W = 3).
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0] resultSrcE;
  logic       PCSrcE, regWriteM, regWriteW, memReqM, mem_ready;
  logic       stallF, stallD, stallE, stallM, flushD, flushE, flushW;
  logic [1:0] forwardAE, forwardBE;
  logic       mem_timeout_err;
  logic [2:0] stall_cnt, flush_cnt;

  int total = 0;
  int bad   = 0;

  // {stallF, stallD, stallE, stallM, flushD, flushE, flushW}
  wire [6:0] ctl = {stallF, stallD, stallE, stallM, flushD, flushE, flushW};
  localparam logic [6:0] CtlIdle   = 7'b0000000;
  localparam logic [6:0] CtlFreeze = 7'b1111001;
  localparam logic [6:0] CtlReset  = 7'b0000111;
  localparam logic [6:0] CtlLw     = 7'b1100010;
  localparam logic [6:0] CtlBranch = 7'b0000110;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .resultSrcE(resultSrcE), .PCSrcE(PCSrcE), .RdM(RdM), .RdW(RdW),
    .regWriteM(regWriteM), .regWriteW(regWriteW), .memReqM(memReqM), .mem_ready(mem_ready),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
    .flushD(flushD), .flushE(flushE), .flushW(flushW),
    .forwardAE(forwardAE), .forwardBE(forwardBE), .mem_timeout_err(mem_timeout_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    Rs1D = 5'd0; Rs2D = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0; RdE = 5'd0; RdM = 5'd0; RdW = 5'd0;
    resultSrcE = 2'b00; PCSrcE = 1'b0; regWriteM = 1'b0; regWriteW = 1'b0;
    memReqM = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    regWriteM = 1'b1; RdM = 5'd3; Rs1E = 5'd3; Rs2E = 5'd3;
    resultSrcE = 2'b01; RdE = 5'd4; Rs1D = 5'd4; memReqM = 1'b1;
    #1;
    total++; if (ctl !== CtlReset) begin bad++; $display("FAIL reset_ctl got=%b exp=%b", ctl, CtlReset); end
    total++; if ({forwardAE, forwardBE} !== 4'b0000) begin bad++; $display("FAIL reset_fwd got=%b exp=0000", {forwardAE, forwardBE}); end
    total++; if ({mem_timeout_err, stall_cnt, flush_cnt} !== 7'd0) begin bad++; $display("FAIL reset_regs got=%b exp=0", {mem_timeout_err, stall_cnt, flush_cnt}); end
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_load_use();
    do_reset();
    @(negedge clk);
    resultSrcE = 2'b01; RdE = 5'd5; Rs1D = 5'd5;
    #1;
    total++; if (ctl !== CtlLw) begin bad++; $display("FAIL lw_ctl got=%b exp=%b", ctl, CtlLw); end
    @(negedge clk);
    idle_inputs();
    #1;
    total++; if (ctl !== CtlIdle) begin bad++; $display("FAIL lw_release got=%b exp=%b", ctl, CtlIdle); end
    total++; if ({stall_cnt, flush_cnt} !== {3'd1, 3'd1}) begin bad++; $display("FAIL lw_cnt got=%0d/%0d exp=1/1", stall_cnt, flush_cnt); end
    @(negedge clk);
    // Rs2D path and RdE == x0 suppression
    resultSrcE = 2'b01; RdE = 5'd9; Rs2D = 5'd9;
    #1;
    total++; if (ctl !== CtlLw) begin bad++; $display("FAIL lw_rs2 got=%b exp=%b", ctl, CtlLw); end
    RdE = 5'd0; Rs2D = 5'd0;
    #1;
    total++; if (ctl !== CtlIdle) begin bad++; $display("FAIL lw_x0 got=%b exp=%b", ctl, CtlIdle); end
    resultSrcE = 2'b00; RdE = 5'd9; Rs2D = 5'd9;
    #1;
    total++; if (ctl !== CtlIdle) begin bad++; $display("FAIL lw_notload got=%b exp=%b", ctl, CtlIdle); end
    idle_inputs();
  endtask

  task automatic test_forward();
    do_reset();
    @(negedge clk);
    regWriteM = 1'b1; regWriteW = 1'b1; RdM = 5'd7; RdW = 5'd7; Rs2E = 5'd7; Rs1E = 5'd7;
    #1;
    total++; if ({forwardAE, forwardBE} !== 4'b1010) begin bad++; $display("FAIL fwd_mem_prio got=%b exp=1010", {forwardAE, forwardBE}); end
    RdM = 5'd0;
    #1;
    total++; if (forwardBE !== 2'b01) begin bad++; $display("FAIL fwd_wb got=%b exp=01", forwardBE); end
    RdW = 5'd0;
    #1;
    total++; if ({forwardAE, forwardBE} !== 4'b0000) begin bad++; $display("FAIL fwd_none got=%b exp=0000", {forwardAE, forwardBE}); end
    RdM = 5'd7; RdW = 5'd7; regWriteM = 1'b0; Rs1E = 5'd3;
    #1;
    total++; if ({forwardAE, forwardBE} !== 4'b0001) begin bad++; $display("FAIL fwd_nowrm got=%b exp=0001", {forwardAE, forwardBE}); end
    regWriteM = 1'b1; RdM = 5'd3; regWriteW = 1'b0;
    #1;
    total++; if ({forwardAE, forwardBE} !== 4'b1000) begin bad++; $display("FAIL fwd_split got=%b exp=1000", {forwardAE, forwardBE}); end
    idle_inputs();
  endtask

  task automatic test_branch_vs_lw();
    do_reset();
    @(negedge clk);
    PCSrcE = 1'b1; resultSrcE = 2'b01; RdE = 5'd6; Rs1D = 5'd6;
    #1;
    total++; if (ctl !== CtlBranch) begin bad++; $display("FAIL br_lw_ctl got=%b exp=%b", ctl, CtlBranch); end
    @(negedge clk);
    idle_inputs();
    #1;
    total++; if ({stall_cnt, flush_cnt} !== {3'd0, 3'd1}) begin bad++; $display("FAIL br_cnt got=%0d/%0d exp=0/1", stall_cnt, flush_cnt); end
  endtask

  task automatic test_mem_wait();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      memReqM = 1'b1; PCSrcE = 1'b1; mem_ready = (i == 3);
      #1;
      total++; if (ctl !== CtlFreeze) begin bad++; $display("FAIL mw_freeze[%0d] got=%b exp=%b", i, ctl, CtlFreeze); end
    end
    @(negedge clk);
    PCSrcE = 1'b0; mem_ready = 1'b1;
    #1;
    total++; if (ctl !== CtlIdle) begin bad++; $display("FAIL mw_exit got=%b exp=%b", ctl, CtlIdle); end
    total++; if ({mem_timeout_err, stall_cnt, flush_cnt} !== {1'b0, 3'd4, 3'd0}) begin bad++; $display("FAIL mw_regs got=%b exp=0100000", {mem_timeout_err, stall_cnt, flush_cnt}); end
    idle_inputs();
  endtask

  task automatic test_watchdog();
    do_reset();
    // Cycle 0 is RUN entering the wait; cycles 1..4 are MEM_WAIT with counter 0..3.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      memReqM = 1'b1; mem_ready = 1'b0;
      #1;
      total++; if (mem_timeout_err !== (i == 5)) begin bad++; $display("FAIL wd_err[%0d] got=%b exp=%b", i, mem_timeout_err, (i == 5)); end
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      memReqM = 1'b0; mem_ready = 1'b1;
      #1;
      total++; if ({ctl, mem_timeout_err} !== {CtlFreeze, 1'b1}) begin bad++; $display("FAIL wd_stuck[%0d] got=%b exp=%b", i, {ctl, mem_timeout_err}, {CtlFreeze, 1'b1}); end
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if ({mem_timeout_err, stall_cnt, flush_cnt} !== 7'd0) begin bad++; $display("FAIL wd_rst_regs got=%b exp=0", {mem_timeout_err, stall_cnt, flush_cnt}); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    total++; if ({ctl, mem_timeout_err} !== {CtlIdle, 1'b0}) begin bad++; $display("FAIL wd_run got=%b exp=%b", {ctl, mem_timeout_err}, {CtlIdle, 1'b0}); end
    idle_inputs();
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      resultSrcE = 2'b01; RdE = 5'd2; Rs1D = 5'd2;
      #1;
      total++; if (stall_cnt !== 3'((i > 7) ? 7 : i)) begin bad++; $display("FAIL sat_stall[%0d] got=%0d exp=%0d", i, stall_cnt, (i > 7) ? 7 : i); end
    end
    @(negedge clk);
    idle_inputs();
    #1;
    total++; if ({stall_cnt, flush_cnt} !== {3'd7, 3'd7}) begin bad++; $display("FAIL sat_final got=%0d/%0d exp=7/7", stall_cnt, flush_cnt); end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_load_use();
    test_forward();
    test_branch_vs_lw();
    test_mem_wait();
    test_watchdog();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
